// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared register map, bit positions and debounce states for keypad_scan16
package keypad_pkg;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_NEMPTY = 0;
    localparam int ST_OVF    = 1;
    localparam int ST_HELD   = 2;
    localparam int ST_COUNT  = 4;

    localparam int CTRL_INT_EN  = 0;
    localparam int CTRL_OVF_CLR = 1;

    typedef enum logic [1:0] {
        KP_IDLE,
        KP_CAND,
        KP_HELD
    } kp_state_t;

    // Frame bits are stored column-major (col*4+row); keycodes are row*4+col.
    function automatic logic [3:0] kp_keycode(input logic [3:0] frame_bit);
        return {frame_bit[1:0], frame_bit[3:2]};
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// rtl/keypad_fifo.sv - small keycode queue; a pop frees room for a same-cycle push
module keypad_fifo
    import keypad_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [3:0]    push_data,
    input  logic          pop,
    output logic [3:0]    head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          drop
);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & ~do_push;
    assign head    = empty ? 4'h0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scan16.sv
// rtl/keypad_scan16.sv - 4x4 keypad scanner with frame debounce, keycode FIFO and bus registers
module keypad_scan16
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  o_col,
    input  logic [3:0]  i_row,
    input  logic        i_cs,
    input  logic        i_re,
    input  logic        i_we,
    input  logic [3:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wdata_sel,
    output logic [31:0] o_rdata,
    output logic        o_int
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [SW-1:0] slot_cnt;
    logic [1:0]    col;
    logic [15:0]   frame;
    logic [15:0]   frame_next;
    logic          slot_end;
    logic          frame_done;

    logic [4:0]    ones;
    logic [3:0]    hit_bit;
    logic          is_none;
    logic          is_single;
    logic [3:0]    key;

    kp_state_t     state, state_nx;
    logic [3:0]    cand, cand_nx;
    logic [DW-1:0] stab, stab_nx;
    logic [DW-1:0] rel, rel_nx;
    logic          push;

    logic [3:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic [2:0]    count3;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_drop;
    logic          rd_pop;
    logic          ctrl_wr;
    logic          int_en;
    logic          ovf;
    logic          unused_bits;

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= i_row;
            row_sync <= row_meta;
        end
    end

    assign slot_end   = (slot_cnt == SW'(SCAN_DIV - 1));
    assign frame_done = slot_end && (col == 2'd3);

    // The last column's sample is merged here so the frame is judged on the edge it completes.
    always_comb begin
        frame_next = frame;
        frame_next[col*4 +: 4] = ~row_sync;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt <= '0;
            col      <= 2'd0;
            o_col    <= 4'b1110;
            frame    <= '0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            col      <= col + 2'd1;
            o_col    <= ~(4'b0001 << (col + 2'd1));
            frame    <= frame_next;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    always_comb begin
        ones    = '0;
        hit_bit = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame_next[i]) begin
                ones    = ones + 5'd1;
                hit_bit = 4'(i);
            end
        end
    end

    assign is_none   = (ones == 5'd0);
    assign is_single = (ones == 5'd1);
    assign key       = kp_keycode(hit_bit);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= KP_IDLE;
            cand  <= '0;
            stab  <= '0;
            rel   <= '0;
        end else begin
            state <= state_nx;
            cand  <= cand_nx;
            stab  <= stab_nx;
            rel   <= rel_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        stab_nx  = stab;
        rel_nx   = rel;
        push     = 1'b0;
        if (frame_done) begin
            case (state)
                KP_IDLE: begin
                    if (is_single) begin
                        cand_nx = key;
                        if (DEBOUNCE_FRAMES == 1) begin
                            push     = 1'b1;
                            state_nx = KP_HELD;
                            stab_nx  = '0;
                            rel_nx   = '0;
                        end else begin
                            stab_nx  = DW'(1);
                            state_nx = KP_CAND;
                        end
                    end
                end
                KP_CAND: begin
                    if (is_single && (key == cand)) begin
                        if (stab + 1'b1 == DW'(DEBOUNCE_FRAMES)) begin
                            push     = 1'b1;
                            state_nx = KP_HELD;
                            stab_nx  = '0;
                            rel_nx   = '0;
                        end else begin
                            stab_nx = stab + 1'b1;
                        end
                    end else begin
                        state_nx = KP_IDLE;
                        stab_nx  = '0;
                    end
                end
                KP_HELD: begin
                    if (is_none) begin
                        if (rel + 1'b1 == DW'(DEBOUNCE_FRAMES)) begin
                            state_nx = KP_IDLE;
                            rel_nx   = '0;
                        end else begin
                            rel_nx = rel + 1'b1;
                        end
                    end else begin
                        rel_nx = '0;
                    end
                end
                default: state_nx = KP_IDLE;
            endcase
        end
    end

    assign rd_pop  = i_cs & i_re & (i_addr[3:2] == REG_DATA);
    assign ctrl_wr = i_cs & i_we & (i_addr[3:2] == REG_CTRL) & i_wdata_sel[0];

    keypad_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (key),
        .pop       (rd_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            int_en <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                int_en <= i_wdata[CTRL_INT_EN];
            end
            if (fifo_drop) begin
                ovf <= 1'b1;
            end else if (ctrl_wr && i_wdata[CTRL_OVF_CLR]) begin
                ovf <= 1'b0;
            end
        end
    end

    assign count3 = 3'(fifo_count);

    always_comb begin
        o_rdata = '0;
        case (i_addr[3:2])
            REG_STATUS: begin
                o_rdata[ST_NEMPTY]       = ~fifo_empty;
                o_rdata[ST_OVF]          = ovf;
                o_rdata[ST_HELD]         = (state == KP_HELD);
                o_rdata[ST_COUNT +: 3]   = count3;
            end
            REG_DATA: o_rdata[3:0]        = fifo_head;
            REG_CTRL: o_rdata[CTRL_INT_EN] = int_en;
            default:  o_rdata = '0;
        endcase
    end

    assign o_int = int_en & ~fifo_empty;

    assign unused_bits = ^{i_addr[1:0], i_wdata[31:2], i_wdata_sel[3:1], fifo_full};

endmodule

// File: tb/tb_keypad_scan16.sv
// tb/tb_keypad_scan16.sv - randomized scoreboard bench for keypad_scan16
module tb_keypad_scan16;

    localparam int SCAN_DIV = 4;
    localparam int DF       = 2;
    localparam int DEPTH    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  o_col;
    logic [3:0]  i_row;
    logic        i_cs = 1'b0;
    logic        i_re = 1'b0;
    logic        i_we = 1'b0;
    logic [3:0]  i_addr = 4'h0;
    logic [31:0] i_wdata = 32'h0;
    logic [3:0]  i_wdata_sel = 4'h0;
    logic [31:0] o_rdata;
    logic        o_int;

    keypad_scan16 #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DF),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .o_col       (o_col),
        .i_row       (i_row),
        .i_cs        (i_cs),
        .i_re        (i_re),
        .i_we        (i_we),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_wdata_sel (i_wdata_sel),
        .o_rdata     (o_rdata),
        .o_int       (o_int)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit started = 1'b0;

    // Physical key matrix: keycode row*4+col; row is pulled low when a pressed key meets the driven column.
    logic [15:0] pressed = 16'h0;
    always_comb begin
        i_row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            i_row[r] = ~|(pressed[r*4 +: 4] & ~o_col);
        end
    end

    logic [3:0] m_q[$];
    bit         m_ovf = 1'b0;
    bit         m_latched = 1'b0;
    bit         m_int_en = 1'b0;
    int         m_streak = 0;
    int         m_quiet = 0;
    int         m_key = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        logic [3:0] exp_col;
        if (started) begin
            exp_col = ~(4'b0001 << ((cyc / 4) % 4));
            check("o_col", {28'b0, o_col}, {28'b0, exp_col});
        end
    end

    // Scoreboard monitor: every DATA read is checked against the oldest modelled code.
    always @(negedge clk) begin
        logic [31:0] e;
        if (i_cs && i_re && i_addr[3:2] == 2'd1) begin
            e = 32'h0;
            if (m_q.size() != 0) e = {28'b0, m_q.pop_front()};
            check("data", o_rdata, e);
        end
    end

    function automatic void model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_latched = 1'b0;
        m_int_en = 1'b0;
        m_streak = 0;
        m_quiet = 0;
        m_key = 0;
    endfunction

    function automatic void model_push(input int k);
        if (m_q.size() < DEPTH) m_q.push_back(4'(k));
        else                    m_ovf = 1'b1;
    endfunction

    // Keys in columns 0/1 are seen in the first half-frame, columns 2/3 in the second.
    function automatic logic [15:0] seen_of(input logic [15:0] h1, input logic [15:0] h2);
        logic [15:0] s;
        for (int c = 0; c < 16; c++) s[c] = ((c % 4) < 2) ? h1[c] : h2[c];
        return s;
    endfunction

    // A press is accepted after DF consecutive frames showing the same lone key,
    // then ignored until DF consecutive empty frames have been seen.
    function automatic void model_frame(input logic [15:0] seen);
        int n;
        int k;
        n = $countones(seen);
        k = 0;
        for (int i = 0; i < 16; i++) if (seen[i]) k = i;
        if (m_latched) begin
            if (n == 0) begin
                m_quiet++;
                if (m_quiet == DF) m_latched = 1'b0;
            end else begin
                m_quiet = 0;
            end
        end else if (n == 1 && (m_streak == 0 || k == m_key)) begin
            m_key = k;
            m_streak++;
        end else begin
            m_streak = 0;
        end
        if (!m_latched && m_streak == DF) begin
            model_push(m_key);
            m_latched = 1'b1;
            m_streak = 0;
            m_quiet = 0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        started = 1'b1;
        step();
        model_reset();
        reset = 1'b0;
    endtask

    task automatic frame(input logic [15:0] h1, input logic [15:0] h2, input bit rd_last = 1'b0);
        while (cyc % 16 != 0) step();
        pressed = h1;
        repeat (8) step();
        pressed = h2;
        repeat (7) step();
        if (rd_last) begin
            i_cs = 1'b1; i_re = 1'b1; i_addr = 4'h4;
        end
        step();
        i_cs = 1'b0; i_re = 1'b0;
        model_frame(seen_of(h1, h2));
    endtask

    task automatic wr_ctrl(input logic [31:0] d);
        i_cs = 1'b1; i_we = 1'b1; i_addr = 4'h8; i_wdata = d; i_wdata_sel = 4'h1;
        step();
        i_cs = 1'b0; i_we = 1'b0; i_wdata_sel = 4'h0;
        m_int_en = d[0];
        if (d[1]) m_ovf = 1'b0;
    endtask

    task automatic rd_data();
        i_cs = 1'b1; i_re = 1'b1; i_addr = 4'h4;
        step();
        i_cs = 1'b0; i_re = 1'b0;
    endtask

    task automatic rd_status(input string nm);
        logic [31:0] exp_st;
        exp_st = 32'h0;
        exp_st[6:4] = 3'(m_q.size());
        exp_st[2] = m_latched;
        exp_st[1] = m_ovf;
        exp_st[0] = (m_q.size() != 0);
        i_cs = 1'b1; i_addr = 4'h0; #1;
        check({nm, "_status"}, o_rdata, exp_st);
        check({nm, "_int"}, {31'b0, o_int}, {31'b0, m_int_en && (m_q.size() != 0)});
        i_addr = 4'h8; #1;
        check({nm, "_ctrl"}, o_rdata, {31'b0, m_int_en});
        i_addr = 4'hC; #1;
        check({nm, "_rsvd"}, o_rdata, 32'h0);
        i_cs = 1'b0; i_addr = 4'h0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] used;
        logic [15:0] kbit;
        logic [15:0] prev;
        logic [15:0] h1;
        logic [15:0] h2;
        int          k;

        do_reset();
        rd_status("reset");
        repeat (7) frame(16'h0, 16'h0);
        rd_status("idle");

        wr_ctrl(32'h1);
        repeat (10) frame(16'h0200, 16'h0200);
        rd_status("held9");
        repeat (3) frame(16'h0, 16'h0);
        rd_status("push9");
        rd_data();
        rd_status("pop9");

        repeat (2) begin
            frame(16'h0040, 16'h0040);
            frame(16'h0040, 16'h0000);
        end
        repeat (4) frame(16'h0040, 16'h0040);
        repeat (3) frame(16'h0, 16'h0);
        rd_status("bounce");
        rd_data();

        repeat (3) frame(16'h0021, 16'h0021);
        rd_status("multi");
        repeat (3) frame(16'h0001, 16'h0001);
        repeat (3) frame(16'h0, 16'h0);
        rd_status("multi_rel");
        rd_data();

        used = 16'h0;
        for (int i = 0; i < 5; i++) begin
            do k = $urandom_range(0, 15); while (used[k]);
            used[k] = 1'b1;
            kbit = 16'h1 << k;
            repeat (3) frame(kbit, kbit);
            repeat (3) frame(16'h0, 16'h0);
        end
        rd_status("ovf");
        repeat (4) rd_data();
        rd_status("ovf_drained");
        wr_ctrl(32'h3);
        rd_status("ovf_clr");

        for (int i = 0; i < 5; i++) begin
            kbit = 16'h1 << $urandom_range(0, 15);
            if (i < 4) begin
                repeat (3) frame(kbit, kbit);
            end else begin
                frame(kbit, kbit);
                frame(kbit, kbit, 1'b1);
            end
            repeat (3) frame(16'h0, 16'h0);
        end
        rd_status("full_pop");
        repeat (5) rd_data();
        rd_status("full_drained");

        frame(16'h0004, 16'h0004);
        frame(16'h0004, 16'h0004);
        repeat (3) frame(16'h0, 16'h0);
        pressed = 16'h0008;
        frame(16'h0008, 16'h0008);
        repeat (5) step();
        pressed = 16'h0;
        do_reset();
        rd_status("rst_cand");
        repeat (4) frame(16'h0, 16'h0);
        rd_status("no_late");

        wr_ctrl(32'h1);
        prev = 16'h0;
        repeat (40) begin
            case ($urandom_range(0, 3))
                0:       h1 = 16'h0;
                1:       h1 = 16'h1 << $urandom_range(0, 15);
                2:       h1 = prev;
                default: h1 = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            endcase
            h2 = ($urandom_range(0, 3) == 0) ? (16'h1 << $urandom_range(0, 15)) : h1;
            prev = h1;
            frame(h1, h2);
        end
        repeat (3) frame(16'h0, 16'h0);
        rd_status("random");
        while (m_q.size() != 0) rd_data();
        rd_data();
        rd_status("random_drained");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
